canny_tile_buffer: RTL and testbench

Parametrised, double-buffered input stage for the CANNY edge pipeline. It accepts NLANE pixels per cycle and assembles them into a TILE_W x TILE_H tile. It then streams every interior 3x3 neighbourhood to the filter datapath, one window per cycle. Unlike the current single-buffer pause/load_end scheme, a second bank loads the next tile while the current tile drains, with valid/ready on both sides.

---
 rtl/canny_pkg.sv | 41 ++++
 rtl/canny_tile_bank.sv | 54 +++++
 rtl/canny_tile_buffer.sv | 202 ++++++++++++++++++++
 tb/tb_canny_tile_buffer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/canny_pkg.sv
// Shared definitions for the CANNY tile input stage.
// Holds the default geometry, pixel/window types, the per-bank state encoding and
// helpers that derive beat/window counts and index widths from the tile geometry.
package canny_pkg;

    localparam int unsigned BIT_W_DEF  = 4;
    localparam int unsigned NLANE_DEF  = 5;
    localparam int unsigned TILE_W_DEF = 20;
    localparam int unsigned TILE_H_DEF = 20;

    typedef logic [BIT_W_DEF-1:0] pixel_t;
    typedef pixel_t [8:0]         window_t;

    // Lifecycle of one storage bank.
    typedef enum logic [1:0] {
        BankEmpty,
        BankFilling,
        BankFull,
        BankDraining
    } bank_state_e;

    function automatic int unsigned beats_per_tile(input int unsigned tile_w,
                                                   input int unsigned tile_h,
                                                   input int unsigned nlane);
        return (tile_w * tile_h) / nlane;
    endfunction

    function automatic int unsigned windows_per_tile(input int unsigned tile_w,
                                                     input int unsigned tile_h);
        return (tile_w - 2) * (tile_h - 2);
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned BEATS_PER_TILE   = beats_per_tile(TILE_W_DEF, TILE_H_DEF, NLANE_DEF);
    localparam int unsigned WINDOWS_PER_TILE = windows_per_tile(TILE_W_DEF, TILE_H_DEF);

endpackage

// File: rtl/canny_tile_bank.sv
// One tile bank: TILE_H x TILE_W pixels held in flops.
// Ports:
//   clk_i      clock
//   we_i       write strobe for one beat of NLANE pixels
//   wr_row_i   tile row being written
//   wr_beat_i  beat index within the row (column = beat * NLANE + lane)
//   wr_data_i  NLANE pixels, lane 0 leftmost
//   rd_row_i   top-left row of the 3x3 window
//   rd_col_i   top-left column of the 3x3 window
//   win_o      combinational 3x3 window, element (i,j) at [(3*i+j)*BIT_W +: BIT_W]
module canny_tile_bank
    import canny_pkg::*;
#(
    parameter int unsigned BIT_W  = BIT_W_DEF,
    parameter int unsigned NLANE  = NLANE_DEF,
    parameter int unsigned TILE_W = TILE_W_DEF,
    parameter int unsigned TILE_H = TILE_H_DEF,
    localparam int unsigned ROW_W  = idx_w(TILE_H),
    localparam int unsigned COL_W  = idx_w(TILE_W),
    localparam int unsigned BEAT_W = idx_w(TILE_W / NLANE)
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic [ROW_W-1:0]       wr_row_i,
    input  logic [BEAT_W-1:0]      wr_beat_i,
    input  logic [NLANE*BIT_W-1:0] wr_data_i,
    input  logic [ROW_W-1:0]       rd_row_i,
    input  logic [COL_W-1:0]       rd_col_i,
    output logic [9*BIT_W-1:0]     win_o
);

    logic [BIT_W-1:0] mem_q [TILE_H][TILE_W];

    // Storage carries no reset: bank state in the parent decides what is valid.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int c = 0; c < int'(TILE_W); c++) begin
                if (wr_beat_i == BEAT_W'(c / int'(NLANE))) begin
                    mem_q[wr_row_i][c] <= wr_data_i[(c % int'(NLANE))*BIT_W +: BIT_W];
                end
            end
        end
    end

    always_comb begin
        win_o = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                win_o[(3*i+j)*BIT_W +: BIT_W] = mem_q[rd_row_i + ROW_W'(i)][rd_col_i + COL_W'(j)];
            end
        end
    end

endmodule

// File: rtl/canny_tile_buffer.sv
// Double-buffered tile input stage: one bank loads the next tile while the other streams
// every interior 3x3 neighbourhood, one window per cycle, through a registered output.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   pixel_in   NLANE pixels of one row, lane 0 leftmost
//   in_valid   beat valid;           in_ready   bank under load can take a beat
//   win_out    3x3 window, element (i,j) at [(3*i+j)*BIT_W +: BIT_W]
//   win_valid  window valid;         win_ready  downstream accepts window
//   win_first  first window of tile; win_last   last window of tile
//   tile_done  one-cycle pulse after the last window of a tile is accepted
module canny_tile_buffer
    import canny_pkg::*;
#(
    parameter int unsigned BIT_W  = BIT_W_DEF,
    parameter int unsigned NLANE  = NLANE_DEF,
    parameter int unsigned TILE_W = TILE_W_DEF,
    parameter int unsigned TILE_H = TILE_H_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NLANE*BIT_W-1:0] pixel_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [9*BIT_W-1:0]     win_out,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic                   win_first,
    output logic                   win_last,
    output logic                   tile_done
);

    localparam int unsigned BPR    = TILE_W / NLANE;
    localparam int unsigned ROW_W  = idx_w(TILE_H);
    localparam int unsigned COL_W  = idx_w(TILE_W);
    localparam int unsigned BEAT_W = idx_w(BPR);

    // Drain counters hold the top-left corner of the window, so centres run 1..N-2.
    localparam logic [ROW_W-1:0]  LAST_ROW     = ROW_W'(TILE_H - 3);
    localparam logic [COL_W-1:0]  LAST_COL     = COL_W'(TILE_W - 3);
    localparam logic [ROW_W-1:0]  LAST_WR_ROW  = ROW_W'(TILE_H - 1);
    localparam logic [BEAT_W-1:0] LAST_WR_BEAT = BEAT_W'(BPR - 1);

    bank_state_e bank_st_q [2];
    bank_state_e bank_st_d [2];
    logic wb_q, wb_d;
    logic rb_q, rb_d;

    logic [ROW_W-1:0]  wr_row_q, wr_row_d;
    logic [BEAT_W-1:0] wr_beat_q, wr_beat_d;
    logic [ROW_W-1:0]  rd_row_q, rd_row_d;
    logic [COL_W-1:0]  rd_col_q, rd_col_d;

    logic [9*BIT_W-1:0] win_out_q, win_out_d;
    logic               win_valid_q, win_valid_d;
    logic               win_first_q, win_first_d;
    logic               win_last_q, win_last_d;
    logic               tile_done_q, tile_done_d;

    logic               wr_en, wr_last;
    logic               out_free, last_taken, launch, issue;
    logic               rd_sel;
    logic [ROW_W-1:0]   rd_row;
    logic [COL_W-1:0]   rd_col;
    logic [9*BIT_W-1:0] bank_win [2];

    assign in_ready   = (bank_st_q[wb_q] == BankEmpty) || (bank_st_q[wb_q] == BankFilling);
    assign wr_en      = in_valid && in_ready;
    assign wr_last    = (wr_row_q == LAST_WR_ROW) && (wr_beat_q == LAST_WR_BEAT);

    assign out_free   = !win_valid_q || win_ready;
    assign last_taken = win_valid_q && win_ready && win_last_q;
    // On the edge that retires a tile, a waiting full bank starts at once so there is no bubble.
    assign launch     = last_taken && (bank_st_q[!rb_q] == BankFull);

    assign rd_sel = launch ? !rb_q : rb_q;
    assign rd_row = launch ? '0 : rd_row_q;
    assign rd_col = launch ? '0 : rd_col_q;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        canny_tile_bank #(
            .BIT_W  (BIT_W),
            .NLANE  (NLANE),
            .TILE_W (TILE_W),
            .TILE_H (TILE_H)
        ) u_bank (
            .clk_i     (clk),
            .we_i      (wr_en && (wb_q == 1'(b))),
            .wr_row_i  (wr_row_q),
            .wr_beat_i (wr_beat_q),
            .wr_data_i (pixel_in),
            .rd_row_i  (rd_row),
            .rd_col_i  (rd_col),
            .win_o     (bank_win[b])
        );
    end

    always_comb begin
        bank_st_d   = bank_st_q;
        wb_d        = wb_q;
        rb_d        = rb_q;
        wr_row_d    = wr_row_q;
        wr_beat_d   = wr_beat_q;
        rd_row_d    = rd_row_q;
        rd_col_d    = rd_col_q;
        win_out_d   = win_out_q;
        win_valid_d = win_valid_q;
        win_first_d = win_first_q;
        win_last_d  = win_last_q;
        tile_done_d = 1'b0;
        issue       = 1'b0;

        // Write side only ever touches an EMPTY/FILLING bank, the read side only FULL/DRAINING.
        if (wr_en) begin
            if (wr_last) begin
                bank_st_d[wb_q] = BankFull;
                wb_d            = !wb_q;
                wr_row_d        = '0;
                wr_beat_d       = '0;
            end else begin
                bank_st_d[wb_q] = BankFilling;
                if (wr_beat_q == LAST_WR_BEAT) begin
                    wr_beat_d = '0;
                    wr_row_d  = wr_row_q + ROW_W'(1);
                end else begin
                    wr_beat_d = wr_beat_q + BEAT_W'(1);
                end
            end
        end

        if (out_free) begin
            win_valid_d = 1'b0;
            win_first_d = 1'b0;
            win_last_d  = 1'b0;
        end

        if (last_taken) begin
            bank_st_d[rb_q] = BankEmpty;
            rb_d            = !rb_q;
            tile_done_d     = 1'b1;
            if (launch) begin
                bank_st_d[!rb_q] = BankDraining;
                issue            = 1'b1;
            end
        end else if (out_free && (bank_st_q[rb_q] == BankDraining)) begin
            issue = 1'b1;
        end else if (out_free && (bank_st_q[rb_q] == BankFull)) begin
            bank_st_d[rb_q] = BankDraining;
        end

        if (issue) begin
            win_valid_d = 1'b1;
            win_out_d   = bank_win[rd_sel];
            win_first_d = (rd_row == '0) && (rd_col == '0);
            win_last_d  = (rd_row == LAST_ROW) && (rd_col == LAST_COL);
            if (rd_col == LAST_COL) begin
                rd_col_d = '0;
                rd_row_d = (rd_row == LAST_ROW) ? '0 : rd_row + ROW_W'(1);
            end else begin
                rd_col_d = rd_col + COL_W'(1);
                rd_row_d = rd_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bank_st_q   <= '{BankEmpty, BankEmpty};
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            wr_row_q    <= '0;
            wr_beat_q   <= '0;
            rd_row_q    <= '0;
            rd_col_q    <= '0;
            win_out_q   <= '0;
            win_valid_q <= 1'b0;
            win_first_q <= 1'b0;
            win_last_q  <= 1'b0;
            tile_done_q <= 1'b0;
        end else begin
            bank_st_q   <= bank_st_d;
            wb_q        <= wb_d;
            rb_q        <= rb_d;
            wr_row_q    <= wr_row_d;
            wr_beat_q   <= wr_beat_d;
            rd_row_q    <= rd_row_d;
            rd_col_q    <= rd_col_d;
            win_out_q   <= win_out_d;
            win_valid_q <= win_valid_d;
            win_first_q <= win_first_d;
            win_last_q  <= win_last_d;
            tile_done_q <= tile_done_d;
        end
    end

    assign win_out   = win_out_q;
    assign win_valid = win_valid_q;
    assign win_first = win_first_q;
    assign win_last  = win_last_q;
    assign tile_done = tile_done_q;

endmodule

// File: tb/tb_canny_tile_buffer.sv
// Directed bench for canny_tile_buffer: default geometry plus a small 8x4 / 4-lane instance.
module tb_canny_tile_buffer;
    import canny_pkg::*;

    localparam int W     = int'(TILE_W_DEF);
    localparam int H     = int'(TILE_H_DEF);
    localparam int NL    = int'(NLANE_DEF);
    localparam int PW    = int'(BIT_W_DEF);
    localparam int BPR   = W / NL;
    localparam int BEATS = int'(BEATS_PER_TILE);
    localparam int WINS  = int'(WINDOWS_PER_TILE);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic [NL*PW-1:0]     pixel_in;
    logic                 in_valid, in_ready;
    logic [9*PW-1:0]      win_out;
    logic                 win_valid, win_ready, win_first, win_last, tile_done;

    logic [15:0]          s_pixel_in;
    logic                 s_in_valid, s_in_ready;
    logic [35:0]          s_win_out;
    logic                 s_win_valid, s_win_ready, s_win_first, s_win_last, s_tile_done;

    canny_tile_buffer u_dut (
        .clk       (clk),
        .reset     (reset),
        .pixel_in  (pixel_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .win_out   (win_out),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_first (win_first),
        .win_last  (win_last),
        .tile_done (tile_done)
    );

    canny_tile_buffer #(
        .BIT_W  (4),
        .NLANE  (4),
        .TILE_W (8),
        .TILE_H (4)
    ) u_dut_small (
        .clk       (clk),
        .reset     (reset),
        .pixel_in  (s_pixel_in),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .win_out   (s_win_out),
        .win_valid (s_win_valid),
        .win_ready (s_win_ready),
        .win_first (s_win_first),
        .win_last  (s_win_last),
        .tile_done (s_tile_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Tile t of a run with a given seed: pixel(r,c) = (r*W + c + seed + 7*t) mod 16.
    function automatic logic [PW-1:0] pix(input int t, input int seed, input int r, input int c);
        return PW'((r * W + c + seed + 7 * t) % 16);
    endfunction

    function automatic logic [NL*PW-1:0] beat_data(input int b, input int seed);
        logic [NL*PW-1:0] d;
        int t, k, r, bc;
        t = b / BEATS;
        k = b % BEATS;
        r = k / BPR;
        bc = k % BPR;
        for (int l = 0; l < NL; l++) d[l*PW +: PW] = pix(t, seed, r, bc * NL + l);
        return d;
    endfunction

    // {first, last, window} expected for the widx-th accepted window of a run.
    function automatic logic [63:0] exp_win(input int widx, input int seed);
        logic [9*PW-1:0] w;
        int t, k, r, c;
        t = widx / WINS;
        k = widx % WINS;
        r = 1 + k / (W - 2);
        c = 1 + k % (W - 2);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(3*i+j)*PW +: PW] = pix(t, seed, r - 1 + i, c - 1 + j);
        return {26'd0, (k == 0), (k == WINS - 1), w};
    endfunction

    int          st_last_beat_edge, st_first_valid_cyc, st_valid_cycles, st_tdone;
    int          st_ready_drop_beats, st_ready_rise_cyc, st_first_tdone_cyc;
    int          st_last_hs [4];
    int          st_first_seen [4];
    bit          st_ir_low_after_load;
    logic [63:0] st_first_win;

    task automatic run(input int ntiles, input int seed, input bit bp, input int stop_at);
        int beat = 0;
        int widx = 0;
        int cyc = 0;
        int total_b = ntiles * BEATS;
        bit stalled = 1'b0;
        bit prev_ir = 1'b1;
        logic [63:0] held = '0;
        st_last_beat_edge = -1; st_first_valid_cyc = -1; st_valid_cycles = 0; st_tdone = 0;
        st_ready_drop_beats = -1; st_ready_rise_cyc = -1; st_first_tdone_cyc = -1;
        st_ir_low_after_load = 1'b0; st_first_win = '0;
        for (int i = 0; i < 4; i++) begin
            st_last_hs[i] = -1;
            st_first_seen[i] = -1;
        end
        while (widx < stop_at && cyc < 20000) begin
            if (tile_done) begin
                st_tdone++;
                if (st_first_tdone_cyc < 0) st_first_tdone_cyc = cyc;
            end
            if (!in_ready && prev_ir && st_ready_drop_beats < 0) st_ready_drop_beats = beat;
            if (in_ready && !prev_ir && st_ready_rise_cyc < 0) st_ready_rise_cyc = cyc;
            if (!in_ready && beat >= total_b) st_ir_low_after_load = 1'b1;
            prev_ir = in_ready;
            if (stalled)
                check_eq("stall_hold", {win_valid, win_first, win_last, win_out}, {1'b1, held[37:0]});
            if (win_valid) begin
                if (st_first_valid_cyc < 0) st_first_valid_cyc = cyc;
                st_valid_cycles++;
                if (win_first && widx / WINS < 4 && st_first_seen[widx / WINS] < 0)
                    st_first_seen[widx / WINS] = cyc;
            end
            in_valid  = (beat < total_b);
            pixel_in  = beat_data(beat, seed);
            win_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (win_valid && win_ready) begin
                check_eq($sformatf("win%0d", widx), {win_first, win_last, win_out},
                         exp_win(widx, seed));
                if (widx == 0) st_first_win = {26'd0, win_first, win_last, win_out};
                if (win_last && widx / WINS < 4) st_last_hs[widx / WINS] = cyc + 1;
                widx++;
                stalled = 1'b0;
            end else if (win_valid) begin
                stalled = 1'b1;
                held = {26'd0, win_first, win_last, win_out};
            end else begin
                stalled = 1'b0;
            end
            if (in_valid && in_ready) begin
                if (beat == total_b - 1) st_last_beat_edge = cyc + 1;
                beat++;
            end
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        win_ready = 1'b1;
        check_eq("run_window_count", widx, stop_at);
    endtask

    int s_beat, s_nwin, s_last_at, s_done;

    initial begin
        reset = 1'b0; in_valid = 1'b0; win_ready = 1'b1; pixel_in = '0;
        s_in_valid = 1'b0; s_win_ready = 1'b1; s_pixel_in = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check_eq("rst_win_valid", win_valid, 0);
        check_eq("rst_flags", {win_first, win_last, tile_done}, 0);
        check_eq("rst_win_out", win_out, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_small", {s_win_valid, s_in_ready}, 2'b01);

        // Single tile, no backpressure.
        run(1, 0, 1'b0, WINS);
        check_eq("t1_in_ready_after_load", st_ir_low_after_load, 0);
        check_eq("t1_first_latency", st_first_valid_cyc, st_last_beat_edge + 2);
        check_eq("t1_first_win", st_first_win, {26'd0, 2'b10, 36'hA98654210});
        check_eq("t1_valid_cycles", st_valid_cycles, WINS);
        check_eq("t1_no_early_done", st_tdone, 0);
        check_eq("t1_done_pulse", {tile_done, win_valid}, 2'b10);
        step();
        check_eq("t1_done_clear", {tile_done, win_valid, in_ready}, 3'b001);

        // Three tiles back to back.
        run(3, 3, 1'b0, 3 * WINS);
        check_eq("b2b_ready_drop", st_ready_drop_beats, 2 * BEATS);
        check_eq("b2b_ready_rise", st_ready_rise_cyc, st_first_tdone_cyc);
        check_eq("b2b_nogap_1", st_first_seen[1], st_last_hs[0]);
        check_eq("b2b_nogap_2", st_first_seen[2], st_last_hs[1]);
        check_eq("b2b_valid_cycles", st_valid_cycles, 3 * WINS);
        check_eq("b2b_tdone", st_tdone, 2);
        check_eq("b2b_done_pulse", tile_done, 1);
        step();

        // Random backpressure.
        run(2, 5, 1'b1, 2 * WINS);
        check_eq("bp_tdone", st_tdone, 1);
        check_eq("bp_done_pulse", {tile_done, win_valid}, 2'b10);
        step();

        // Reset after 40 beats of a tile.
        for (int b = 0; b < 40; b++) begin
            in_valid = 1'b1;
            pixel_in = beat_data(b, 9);
            step();
        end
        in_valid = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_eq("rst40_outputs", {win_valid, win_first, win_last, tile_done, win_out}, 0);
        check_eq("rst40_in_ready", in_ready, 1);
        run(1, 11, 1'b0, WINS);
        check_eq("rst40_done", tile_done, 1);
        step();

        // Reset in the middle of a drain with the other bank full.
        run(2, 13, 1'b0, 100);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_eq("rstmid_win_valid", win_valid, 0);
        check_eq("rstmid_win_out", win_out, 0);
        check_eq("rstmid_in_ready", in_ready, 1);
        repeat (4) step();
        check_eq("rstmid_stays_idle", {win_valid, in_ready}, 2'b01);
        run(1, 17, 1'b0, WINS);
        check_eq("rstmid_done", tile_done, 1);
        step();

        // Small geometry: 8 beats of 4 lanes, 12 windows, ramp pixel(r,c) = (r*8+c) mod 16.
        s_beat = 0; s_nwin = 0; s_last_at = 0; s_done = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (s_tile_done) s_done++;
            s_in_valid = (s_beat < 8);
            for (int l = 0; l < 4; l++)
                s_pixel_in[l*4 +: 4] = 4'((s_beat / 2) * 8 + (s_beat % 2) * 4 + l);
            if (s_win_valid) begin
                s_nwin++;
                if (s_nwin == 1)
                    check_eq("small_first", {s_win_first, s_win_last, s_win_out},
                             {2'b10, 36'h210A98210});
                if (s_nwin == 12)
                    check_eq("small_last", {s_win_first, s_win_last, s_win_out},
                             {2'b01, 36'hFED765FED});
                if (s_win_last) s_last_at = s_nwin;
            end
            if (s_in_valid && s_in_ready) s_beat++;
            step();
        end
        s_in_valid = 1'b0;
        check_eq("small_beats", s_beat, 8);
        check_eq("small_nwin", s_nwin, 12);
        check_eq("small_last_at", s_last_at, 12);
        check_eq("small_done", s_done, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
